// File: rtl/brush_raster_if.sv
// rtl/brush_raster_if.sv - brush command and pixel stream signal bundle
interface brush_raster_if #(
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 7,
  parameter int COLOR_W = 8
);
  logic               start;
  logic               abort;
  logic [COORD_W-1:0] x_cursor;
  logic [COORD_W-1:0] y_cursor;
  logic [SIZE_W-1:0]  SIZE;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] color;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic [COLOR_W-1:0] color_out;
  logic               pix_valid;
  logic               pix_ready;
  logic               busy;
  logic               done;

  // Command issuer and framebuffer side
  modport master (
    output start, abort, x_cursor, y_cursor, SIZE, mode, color, pix_ready,
    input  x_coord, y_coord, color_out, pix_valid, busy, done
  );

  // Rasteriser side
  modport slave (
    input  start, abort, x_cursor, y_cursor, SIZE, mode, color, pix_ready,
    output x_coord, y_coord, color_out, pix_valid, busy, done
  );
endinterface

// File: rtl/brush_raster.sv
// rtl/brush_raster.sv - brush box scanner with shape modes, clipping and backpressure
module brush_raster #(
  parameter int COORD_W  = 11,
  parameter int SIZE_W   = 7,
  parameter int COLOR_W  = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic          clock,
  input logic          reset,
  brush_raster_if.slave bus
);
  localparam int CW1 = COORD_W + 1;
  localparam int SW2 = 2 * SIZE_W + 2;
  localparam logic [CW1-1:0] SCR_W = CW1'(SCREEN_W);
  localparam logic [CW1-1:0] SCR_H = CW1'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [SIZE_W-1:0]  s_q, s_d, i_q, i_d, j_q, j_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] color_q, color_d;
  // One extra bit so an off-screen sum can never wrap back on screen
  logic [CW1-1:0]     x_q, x_d, y_q, y_d;

  logic               covered, pix_valid, advance, last_col;
  logic [SIZE_W-1:0]  ni, nj;
  logic signed [SW2-1:0] c_s, di, dj, d2, r2;

  // Shape coverage of the current offset, signed and wide enough for all squares
  always_comb begin
    c_s = signed'(SW2'(s_q >> 1));
    di  = signed'(SW2'(i_q)) - c_s;
    dj  = signed'(SW2'(j_q)) - c_s;
    d2  = di * di + dj * dj;
    r2  = c_s * c_s;
    case (mode_q)
      2'b01:   covered = (i_q == '0) || (i_q == s_q) || (j_q == '0) || (j_q == s_q);
      2'b10:   covered = (d2 <= r2);
      default: covered = 1'b1;
    endcase
  end

  assign pix_valid = (state_q == SCAN) && covered && (x_q < SCR_W) && (y_q < SCR_H);
  assign advance   = (state_q == SCAN) && (!pix_valid || bus.pix_ready);
  assign last_col  = (i_q == s_q);
  assign ni        = last_col ? '0 : i_q + SIZE_W'(1);
  assign nj        = last_col ? j_q + SIZE_W'(1) : j_q;

  // Next-state and datapath: capture on start, step the scan, abort wins over advance
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    s_d     = s_q;
    mode_d  = mode_q;
    color_d = color_q;
    i_d     = i_q;
    j_d     = j_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          x0_d    = bus.x_cursor;
          y0_d    = bus.y_cursor;
          s_d     = bus.SIZE;
          mode_d  = bus.mode;
          color_d = bus.color;
          i_d     = '0;
          j_d     = '0;
          x_d     = {1'b0, bus.x_cursor};
          y_d     = {1'b0, bus.y_cursor};
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (advance) begin
          if (last_col && (j_q == s_q)) begin
            state_d = DONE;
          end else begin
            i_d = ni;
            j_d = nj;
            x_d = {1'b0, x0_q} + CW1'(ni);
            y_d = {1'b0, y0_q} + CW1'(nj);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      s_q     <= '0;
      mode_q  <= '0;
      color_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      i_q     <= i_d;
      j_q     <= j_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.x_coord   = x_q[COORD_W-1:0];
  assign bus.y_coord   = y_q[COORD_W-1:0];
  assign bus.color_out = color_q;
  assign bus.pix_valid = pix_valid;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) && !bus.abort;
endmodule
